// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the scalar data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DMEM_XLEN = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                 we;
        logic [1:0]           size;
        logic                 lock;
        logic [DMEM_XLEN-1:0] addr;
        logic [DMEM_XLEN-1:0] wdata;
        logic                 err;
        logic                 port;
    } dmem_req_t;

    // Number of bytes touched by a normalised access size.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin picker; a lock restricts eligibility to the owner.
module dmem_rr_pick (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    input  logic       lock_owner_i,
    input  logic       lock_active_i,
    output logic [1:0] grant_o
);

    logic [1:0] elig;

    always_comb begin
        elig = valid_i;
        if (lock_active_i) begin
            elig = valid_i & (lock_owner_i ? 2'b10 : 2'b01);
        end
        grant_o = elig;
        // On a tie the port not served last wins.
        if (elig == 2'b11) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the scalar LSU (port 0) and
// vector LSU (port 1): round-robin with bounded lock, checked accesses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 1024,
    parameter int unsigned LOCK_MAX   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid_i,
    output logic [1:0]                 req_ready_o,
    input  logic [1:0]                 req_we_i,
    input  logic [1:0][1:0]            req_size_i,
    input  logic [1:0]                 req_lock_i,
    input  logic [1:0][DATA_WIDTH-1:0] req_addr_i,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata_i,
    output logic [1:0]                 rsp_valid_o,
    output logic [1:0]                 rsp_err_o,
    output logic [1:0][DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                       mem_read_o,
    output logic                       mem_write_o,
    output logic [1:0]                 mem_size_o,
    output logic [DATA_WIDTH-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0]      mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]      mem_rdata_i
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
    localparam int unsigned EXT_W = DATA_WIDTH + 1;

    arb_state_e                 state_q, state_d;
    dmem_req_t                  req_q, req_d;
    logic                       last_q, last_d;
    logic                       lock_act_q, lock_act_d;
    logic                       lock_own_q, lock_own_d;
    logic [CNT_W-1:0]           lock_cnt_q, lock_cnt_d;
    logic [1:0]                 rsp_valid_q, rsp_valid_d;
    logic [1:0]                 rsp_err_q, rsp_err_d;
    logic [1:0][DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0]            grant;
    logic                  can_accept;
    logic                  accept;
    logic                  sel;
    logic [1:0]            size_n;
    logic [DATA_WIDTH-1:0] addr_sel;
    logic [EXT_W-1:0]      end_addr;
    logic                  misalign;
    logic                  out_of_range;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  in_access;
    logic                  mem_go;

    dmem_rr_pick u_pick (
        .valid_i       (req_valid_i),
        .last_i        (last_q),
        .lock_owner_i  (lock_own_q),
        .lock_active_i (lock_act_q),
        .grant_o       (grant)
    );

    assign can_accept  = (state_q == IDLE) || (state_q == RESP);
    assign req_ready_o = can_accept ? grant : 2'b00;
    assign accept      = |req_ready_o;
    assign sel         = grant[1];

    // Alignment and range check on the winning request; size 11 aliases word.
    assign addr_sel     = req_addr_i[sel];
    assign size_n       = (req_size_i[sel] == 2'b11) ? SZ_WORD : req_size_i[sel];
    assign misalign     = ((size_n == SZ_HALF) && addr_sel[0]) ||
                          ((size_n == SZ_WORD) && (addr_sel[1:0] != 2'b00));
    assign end_addr     = EXT_W'(addr_sel) + EXT_W'(size_bytes(size_n));
    assign out_of_range = end_addr > EXT_W'(MEM_SIZE);
    assign cnt_inc      = lock_cnt_q + CNT_W'(1);

    // Pointer and lock are committed in ACCESS from the registered request;
    // the next arbitration is never earlier than RESP, so this is equivalent
    // to updating on the handshake itself.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        last_d      = last_q;
        lock_act_d  = lock_act_q;
        lock_own_d  = lock_own_q;
        lock_cnt_d  = lock_cnt_q;
        rsp_valid_d = '0;
        rsp_err_d   = '0;
        rsp_rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (accept) state_d = ACCESS;
            end
            ACCESS: begin
                state_d = RESP;
                last_d  = req_q.port;
                if (req_q.lock && (cnt_inc != CNT_W'(LOCK_MAX))) begin
                    lock_act_d = 1'b1;
                    lock_own_d = req_q.port;
                    lock_cnt_d = cnt_inc;
                end else begin
                    lock_act_d = 1'b0;
                    lock_cnt_d = '0;
                end
                rsp_valid_d[req_q.port] = 1'b1;
                rsp_err_d[req_q.port]   = req_q.err;
                if (!req_q.err && !req_q.we) begin
                    rsp_rdata_d[req_q.port] = mem_rdata_i;
                end
            end
            RESP: begin
                state_d = accept ? ACCESS : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            req_d = '{we:    req_we_i[sel],
                      size:  size_n,
                      lock:  req_lock_i[sel],
                      addr:  DMEM_XLEN'(addr_sel),
                      wdata: DMEM_XLEN'(req_wdata_i[sel]),
                      err:   misalign | out_of_range,
                      port:  sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            last_q      <= 1'b1;
            lock_act_q  <= 1'b0;
            lock_own_q  <= 1'b0;
            lock_cnt_q  <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            last_q      <= last_d;
            lock_act_q  <= lock_act_d;
            lock_own_q  <= lock_own_d;
            lock_cnt_q  <= lock_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Memory port is a decode of registered state; quiet outside ACCESS.
    assign in_access   = (state_q == ACCESS);
    assign mem_go      = in_access && !req_q.err;
    assign mem_read_o  = mem_go && !req_q.we;
    assign mem_write_o = mem_go && req_q.we;
    assign mem_size_o  = in_access ? req_q.size : 2'b00;
    assign mem_addr_o  = in_access ? DATA_WIDTH'(req_q.addr) : '0;
    assign mem_wdata_o = in_access ? DATA_WIDTH'(req_q.wdata) : '0;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-array model of sdatamem.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic            drv_valid [2];
    logic            drv_we    [2];
    logic [1:0]      drv_size  [2];
    logic            drv_lock  [2];
    logic [DW-1:0]   drv_addr  [2];
    logic [DW-1:0]   drv_wdata [2];

    logic [1:0]         req_valid, req_ready, req_we, req_lock;
    logic [1:0][1:0]    req_size;
    logic [1:0][DW-1:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]         rsp_valid, rsp_err;
    logic               mem_read, mem_write;
    logic [1:0]         mem_size;
    logic [DW-1:0]      mem_addr, mem_wdata, mem_rdata;

    assign req_valid = {drv_valid[1], drv_valid[0]};
    assign req_we    = {drv_we[1], drv_we[0]};
    assign req_lock  = {drv_lock[1], drv_lock[0]};
    assign req_size  = {drv_size[1], drv_size[0]};
    assign req_addr  = {drv_addr[1], drv_addr[0]};
    assign req_wdata = {drv_wdata[1], drv_wdata[0]};

    dmem_arbiter #(.DATA_WIDTH(DW), .MEM_SIZE(1024), .LOCK_MAX(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_lock_i  (req_lock),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_err_o   (rsp_err),
        .rsp_rdata_o (rsp_rdata),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .mem_size_o  (mem_size),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Little-endian byte memory with sign-extending reads.
    logic [7:0] mem [1024];
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (mem_write) begin
            mem[mem_addr[9:0]] <= mem_wdata[7:0];
            if (mem_size != SZ_BYTE) mem[10'(mem_addr[9:0] + 10'd1)] <= mem_wdata[15:8];
            if (mem_size[1]) begin
                mem[10'(mem_addr[9:0] + 10'd2)] <= mem_wdata[23:16];
                mem[10'(mem_addr[9:0] + 10'd3)] <= mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        logic [9:0] a;
        a = mem_addr[9:0];
        case (mem_size)
            SZ_BYTE: mem_rdata = {{24{mem[a][7]}}, mem[a]};
            SZ_HALF: mem_rdata = {{16{mem[10'(a + 10'd1)][7]}}, mem[10'(a + 10'd1)], mem[a]};
            default: mem_rdata = {mem[10'(a + 10'd3)], mem[10'(a + 10'd2)],
                                  mem[10'(a + 10'd1)], mem[a]};
        endcase
    end

    typedef struct {
        int          port;
        logic        we;
        logic        err;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   acc_log[$];
    int   strobe_hist[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one request on port p and hold it until the handshake.
    task automatic issue(input int p, input logic we, input logic [1:0] sz, input logic lk,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rd);
        bit   got;
        exp_t e;
        got = 0;
        drv_valid[p] = 1'b1;
        drv_we[p]    = we;
        drv_size[p]  = sz;
        drv_lock[p]  = lk;
        drv_addr[p]  = addr;
        drv_wdata[p] = wdata;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                got = 1;
                break;
            end
        end
        chk($sformatf("accept_p%0d", p), 32'(got), 32'd1);
        if (got) begin
            e.port = p; e.we = we; e.err = exp_err; e.rdata = exp_rd; e.acc = cyc;
            sb.push_back(e);
            grant_log.push_back(p);
            acc_log.push_back(cyc);
        end
        @(posedge clk);
        #1;
        drv_valid[p] = 1'b0;
    endtask

    // Monitor: pops the scoreboard on each response and checks timing too.
    always @(negedge clk) begin
        exp_t e;
        strobe_hist[cyc % 8] = mem_read ? 1 : (mem_write ? 2 : 0);
        if (mem_read || mem_write) begin
            chk("strobe_onehot", 32'(mem_read & mem_write), 32'd0);
            chk("mem_size_norm", 32'(mem_size == 2'b11), 32'd0);
        end
        if (req_ready == 2'b11) chk("ready_onehot", 32'(req_ready), 32'd1);
        if (rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", 32'(rsp_valid), 32'(2'b01 << e.port));
                chk("rsp_err", 32'(rsp_err[e.port]), 32'(e.err));
                chk("rsp_rdata", rsp_rdata[e.port], e.rdata);
                chk("rsp_latency", 32'(cyc - e.acc), 32'd2);
                chk("strobe_kind", 32'(strobe_hist[(e.acc + 1) % 8]),
                    e.err ? 32'd0 : (e.we ? 32'd2 : 32'd1));
            end
        end else if ((rsp_err != 2'b00) || (rsp_rdata != '0)) begin
            chk("rsp_idle_zero", 32'(rsp_err) | rsp_rdata[0] | rsp_rdata[1], 32'd0);
        end
    end

    task automatic check_grants(input string name, input int exp[]);
        chk({name, "_count"}, 32'(grant_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < grant_log.size(); i++) begin
            chk($sformatf("%s_grant%0d", name, i), 32'(grant_log[i]), 32'(exp[i]));
            if (i > 0) chk($sformatf("%s_gap%0d", name, i), 32'(acc_log[i] - acc_log[i-1]), 32'd2);
        end
        grant_log.delete();
        acc_log.delete();
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_ready"}, 32'(req_ready), 32'd0);
        chk({name, "_strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
        chk({name, "_mem_bus"}, mem_addr | mem_wdata | 32'(mem_size), 32'd0);
        chk({name, "_rsp"}, 32'(rsp_valid) | 32'(rsp_err) | rsp_rdata[0] | rsp_rdata[1], 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        for (int p = 0; p < 2; p++) begin
            drv_valid[p] = 1'b0; drv_we[p] = 1'b0; drv_size[p] = 2'b00;
            drv_lock[p] = 1'b0; drv_addr[p] = '0; drv_wdata[p] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Store then load back a word.
        issue(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        issue(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        check_grants("store_load", '{0, 0});

        // Continuous contention without lock alternates; port 0 served last.
        fork
            begin
                for (int i = 0; i < 3; i++)
                    issue(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
            end
            begin
                for (int i = 0; i < 3; i++)
                    issue(1, 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFFBEEF);
            end
        join
        check_grants("alternate", '{1, 0, 1, 0, 1, 0});

        // Locked burst on port 1 is cut off after eight grants.
        fork
            begin
                for (int i = 0; i < 10; i++)
                    issue(1, 1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
                issue(1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
            end
            issue(0, 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF);
        join
        check_grants("lock", '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1});

        // Alignment and range boundaries on port 1.
        issue(1, 1'b0, SZ_HALF, 1'b0, 32'h21, 32'h0, 1'b1, 32'h0);
        issue(1, 1'b0, SZ_WORD, 1'b0, 32'h3FE, 32'h0, 1'b1, 32'h0);
        issue(1, 1'b0, SZ_BYTE, 1'b0, 32'h3FF, 32'h0, 1'b0, 32'h0);
        issue(1, 1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0);
        issue(1, 1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0);
        issue(1, 1'b0, SZ_WORD, 1'b0, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0);
        issue(1, 1'b1, SZ_WORD, 1'b0, 32'h3FE, 32'h11223344, 1'b1, 32'h0);
        issue(1, 1'b0, 2'b11, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0);
        grant_log.delete();
        acc_log.delete();

        // Sub-word stores and sign extension on port 0.
        issue(0, 1'b1, SZ_BYTE, 1'b0, 32'h40, 32'h12345680, 1'b0, 32'h0);
        issue(0, 1'b0, SZ_BYTE, 1'b0, 32'h40, 32'h0, 1'b0, 32'hFFFFFF80);
        issue(0, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h00000080);
        issue(0, 1'b1, SZ_HALF, 1'b0, 32'h50, 32'hAAAA8001, 1'b0, 32'h0);
        issue(0, 1'b0, SZ_HALF, 1'b0, 32'h50, 32'h0, 1'b0, 32'hFFFF8001);
        issue(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        grant_log.delete();
        acc_log.delete();
        repeat (3) @(posedge clk);
        #1;

        // Reset during the ACCESS cycle of a load.
        drv_valid[0] = 1'b1; drv_we[0] = 1'b0; drv_size[0] = SZ_WORD;
        drv_lock[0] = 1'b0; drv_addr[0] = 32'h10;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[0]) begin
                got = 1;
                break;
            end
        end
        chk("rst_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_in_access", 32'(mem_read), 32'd1);
        drv_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fork
            issue(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
            issue(1, 1'b0, SZ_BYTE, 1'b0, 32'h40, 32'h0, 1'b0, 32'hFFFFFF80);
        join
        check_grants("post_reset", '{0, 1});

        for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("drain", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the scalar data memory. It shares the single byte-addressable memory port between the scalar LSU (port 0) and the vector LSU (port 1). It uses round-robin arbitration with an optional bounded lock for vector bursts, and checks every request for alignment and range before any memory access. It sits between both LSUs and the `sdatamem` instance and is the only driver of that memory's control, address and data inputs.

## Interface
- `DATA_WIDTH`, 32, data and address width.
- `MEM_SIZE`, 1024, memory size in bytes; the range check uses it.
- `LOCK_MAX`, 8, maximum consecutive locked grants to one port before the lock is forced off (≥1).
- Clock and reset: clock `clk`; reset `rst_n`, asynchronous, active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid_i[p]`  in  1 (p=0,1)  request valid.
- `req_ready_o[p]`  out  1  request accepted this cycle when high together with valid.
- `req_we_i[p]`  in  1  1 = store, 0 = load.
- `req_size_i[p]`  in  2  00 = byte, 01 = half, 10/11 = word.
- `req_lock_i[p]`  in  1  hold the grant for this port's next request.
- `req_addr_i[p]`  in  DATA_WIDTH  byte address.
- `req_wdata_i[p]`  in  DATA_WIDTH  store data.
- `rsp_valid_o[p]`  out  1  one-cycle response pulse.
- `rsp_err_o[p]`  out  1  request rejected (misaligned or out of range).
- `rsp_rdata_o[p]`  out  DATA_WIDTH  load data, already sign-extended by memory; 0 on store or error.
- `mem_read_o`, `mem_write_o`  out  1  memory strobes.
- `mem_size_o`  out  2  access size.
- `mem_addr_o`, `mem_wdata_o`  out  DATA_WIDTH  memory address and write data.
- `mem_rdata_i`  in  DATA_WIDTH  combinational read data from memory.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE or RESP with an accepted request: go to ACCESS.
  - RESP with no accepted request: go to IDLE.
  - ACCESS: always go to RESP.
- Acceptance happens only in IDLE or RESP.
  - `req_ready_o[p]` is high only for the grant winner; at most one ready is high.
  - Ready may depend combinationally on `req_valid_i`; valid must not depend on ready.
- Arbitration:
  - One port valid: that port wins.
  - Both valid: the port not served last wins.
  - The last-served pointer updates on every acceptance.
- Lock behaviour:
  - An accepted request with `req_lock_i = 1` sets lock to that port and increments `lock_cnt`.
  - While locked, only the owner can win; the other port's ready stays 0 even if it is valid.
  - The lock clears when the owner is accepted with `req_lock_i = 0`.
  - The lock is forced clear when `lock_cnt` reaches `LOCK_MAX`. That acceptance is the last locked grant; the other port then wins the next arbitration if it is valid.
- The check is computed at acceptance and registered with the request.
  - Misaligned: half with `addr[0] ≠ 0`, or word with `addr[1:0] ≠ 0`.
  - Out of range: `addr + bytes > MEM_SIZE`, computed in DATA_WIDTH+1 bits so there is no wrap.
  - Either condition sets the error flag.
- ACCESS cycle:
  - On a valid request, drive `mem_read_o = !we` or `mem_write_o = we` for exactly this cycle, with size, address and wdata taken from the request register.
  - For loads, capture `mem_rdata_i` at the end of the cycle.
  - On an error request, both strobes stay 0.
- RESP cycle:
  - `rsp_valid_o` pulses for the served port, with `rsp_err_o` and `rsp_rdata_o`.
  - `rsp_rdata_o` is 0 for stores and errors.

## Timing
- Handshake in cycle N → memory strobe in N+1 → `rsp_valid_o` in N+2.
- Back-to-back: a request accepted in the RESP cycle gives one access every 2 cycles.
- Outside ACCESS, all `mem_*` outputs are 0. Outside RESP, all `rsp_*` outputs are 0.
- Reset values:
  - All outputs 0; state IDLE.
  - Last-served pointer = port 1, so port 0 wins the first tie.
  - Lock clear; `lock_cnt` = 0.
- Reset mid-operation:
  - No memory strobe or response is issued after reset.
  - A partially sequenced store is dropped; a store already strobed in ACCESS has completed.
- Size 11 behaves exactly like size 10, including on `mem_size_o`.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum `arb_state_e`;
  - size constants `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - a `dmem_req_t` struct (we, size, lock, addr, wdata, err, port) used for the request register.
- Sub-module `dmem_rr_pick`: a combinational 2-way round-robin picker with a lock mask. Inputs: valids, last-served pointer, lock owner and lock-active. Output: one-hot grant.

## Test plan
- Port 0 store word 0xDEADBEEF at 0x10, then load word at 0x10:
  - `mem_write_o` pulses at N+1;
  - the load gives `rsp_rdata_o[0] = 0xDEADBEEF`, `rsp_err_o = 0` at N+2.
- Both ports valid continuously with no lock → grants alternate 0,1,0,1…, one acceptance every 2 cycles.
- Port 1 issues 10 requests with lock=1, port 0 also valid, `LOCK_MAX = 8` → port 1 gets 8 grants, then port 0 is granted.
- Half load at 0x21, word load at 0x3FE, and byte load at 0x3FF (`MEM_SIZE = 1024`):
  - the first two give `rsp_err_o = 1`, rdata 0, and no memory strobe;
  - the byte load succeeds.
- Byte 0x80 stored at 0x40, then byte load at 0x40 → `rsp_rdata_o = 0xFFFFFF80`.
- Assert `rst_n` low during ACCESS of a load → no `rsp_valid_o`; all outputs 0; after release, port 0 wins the first tie.
